// File: rtl/dsd_cpu_cpu_debug_ocimem_ctl_if.sv
// ----------------------------------------------------------------------------
// dsd_cpu_cpu_debug_ocimem_ctl_if
//
// Purpose : Avalon-style master/slave bus between the OCI memory controller
//           and the debug RAM. Reads have a fixed latency of one cycle:
//           ram_rdata is valid in the cycle after a read is accepted
//           (ram_rd high with ram_waitrequest low).
//
// Signals :
//   ram_addr        word address of the current request
//   ram_rd          read request, held until ram_waitrequest is low
//   ram_wr          write request, held until ram_waitrequest is low
//   ram_wdata       write data, stable while ram_wr is high
//   ram_rdata       read data, one cycle after an accepted read
//   ram_waitrequest RAM stall; the request is accepted in a cycle where it is low
//
// Modports:
//   master  controller side (drives the request)
//   slave   RAM side (drives read data and stall)
// ----------------------------------------------------------------------------
interface dsd_cpu_cpu_debug_ocimem_ctl_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic              ram_wr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              ram_waitrequest;

    modport master (
        output ram_addr,
        output ram_rd,
        output ram_wr,
        output ram_wdata,
        input  ram_rdata,
        input  ram_waitrequest
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        input  ram_wr,
        input  ram_wdata,
        output ram_rdata,
        output ram_waitrequest
    );
endinterface

// File: rtl/dsd_cpu_cpu_debug_ocimem_ctl.sv
// ----------------------------------------------------------------------------
// dsd_cpu_cpu_debug_ocimem_ctl
//
// Purpose : Sequencer between the JTAG debug slave and the on-chip debug RAM.
//           The debug slave issues one-cycle command strobes; this block turns
//           them into single Avalon reads/writes, returns read data on MonDReg
//           and reports completion on monitor_ready.
//
// Commands (accepted only in IDLE, priority b > a > no_action_a):
//   take_action_ocimem_b    write jdo[34:3] at the current address, then +1
//   take_action_ocimem_a    load address from jdo[ADDR_W+25:26] and read;
//                           jdo[25]=1 also clears monitor_error
//   take_no_action_ocimem_a increment address, then read
//   A strobe seen while a transfer is in flight is dropped and sets the sticky
//   monitor_error flag.
//
// Ports:
//   clk, reset      single clock, asynchronous active-high reset
//   jdo             debug-slave data word
//   take_*          command strobes
//   ram             bus master modport to the debug RAM (read latency 1)
//   MonDReg         last read data
//   monitor_ready   high when the last command has completed
//   monitor_error   sticky error flag
//
// Configuration:
//   `define DSD_CPU_OCIMEM_TIMEOUT_EN compiles in a wait counter that aborts a
//   request after TIMEOUT_CYC consecutive stalled cycles (MonDReg is loaded
//   with 32'hDEADDEAD on an aborted read, the address is left unchanged and
//   monitor_error is set). Without the macro a stalled request waits forever.
// ----------------------------------------------------------------------------
module dsd_cpu_cpu_debug_ocimem_ctl #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [37:0]                     jdo,
    input  logic                            take_action_ocimem_a,
    input  logic                            take_no_action_ocimem_a,
    input  logic                            take_action_ocimem_b,
    dsd_cpu_cpu_debug_ocimem_ctl_if.master  ram,
    output logic [31:0]                     MonDReg,
    output logic                            monitor_ready,
    output logic                            monitor_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_DATA = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_DEAD;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [31:0]       mon_dreg_reg, mon_dreg_next;
    logic [31:0]       wdata_reg, wdata_next;
    logic              ready_reg, ready_next;
    logic              error_reg, error_next;
    logic              any_strobe;

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a |
                        take_action_ocimem_b;

`ifdef DSD_CPU_OCIMEM_TIMEOUT_EN
    // At least 8 bits, wider if TIMEOUT_CYC needs it.
    localparam int WAIT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ?
                            $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              timeout_hit;

    // The counter holds the number of stalled cycles already seen, so the
    // current stalled cycle is the TIMEOUT_CYC-th one when it reads
    // TIMEOUT_CYC-1.
    assign timeout_hit = ram.ram_waitrequest &&
                         (wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1));
`endif

    // Bits of jdo that carry nothing for this block.
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        mon_dreg_next = mon_dreg_reg;
        wdata_next    = wdata_reg;
        ready_next    = ready_reg;
        error_next    = error_reg;
`ifdef DSD_CPU_OCIMEM_TIMEOUT_EN
        // Cleared whenever a request is not stalling, so it only ever counts
        // consecutive stalled cycles.
        wait_cnt_next = '0;
`endif

        case (state_reg)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    wdata_next = jdo[34:3];
                    ready_next = 1'b0;
                    state_next = WR_REQ;
                end else if (take_action_ocimem_a) begin
                    addr_next  = jdo[ADDR_W+25:26];
                    if (jdo[25]) begin
                        error_next = 1'b0;
                    end
                    ready_next = 1'b0;
                    state_next = RD_REQ;
                end else if (take_no_action_ocimem_a) begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    ready_next = 1'b0;
                    state_next = RD_REQ;
                end
            end

            RD_REQ: begin
                if (!ram.ram_waitrequest) begin
                    state_next = RD_DATA;
                end
`ifdef DSD_CPU_OCIMEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    mon_dreg_next = ABORT_DATA;
                    error_next    = 1'b1;
                    ready_next    = 1'b1;
                    state_next    = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
`endif
            end

            RD_DATA: begin
                // ram_rdata belongs to the read accepted in the previous cycle.
                mon_dreg_next = ram.ram_rdata;
                ready_next    = 1'b1;
                state_next    = IDLE;
            end

            WR_REQ: begin
                if (!ram.ram_waitrequest) begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
`ifdef DSD_CPU_OCIMEM_TIMEOUT_EN
                else if (timeout_hit) begin
                    // Aborted write: address is not advanced.
                    error_next = 1'b1;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // The debug slave is not supposed to strobe while a transfer is in
        // flight; such a strobe is dropped and flagged.
        if ((state_reg != IDLE) && any_strobe) begin
            error_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg     <= '0;
            mon_dreg_reg <= '0;
            wdata_reg    <= '0;
            ready_reg    <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            addr_reg     <= addr_next;
            mon_dreg_reg <= mon_dreg_next;
            wdata_reg    <= wdata_next;
            ready_reg    <= ready_next;
            error_reg    <= error_next;
        end
    end

`ifdef DSD_CPU_OCIMEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: request strobes decode straight from the state register, so
    // they are glitch-free, mutually exclusive and low in IDLE/RD_DATA.
    // ------------------------------------------------------------------
    assign ram.ram_rd    = (state_reg == RD_REQ);
    assign ram.ram_wr    = (state_reg == WR_REQ);
    assign ram.ram_addr  = addr_reg;
    assign ram.ram_wdata = wdata_reg;

    assign MonDReg       = mon_dreg_reg;
    assign monitor_ready = ready_reg;
    assign monitor_error = error_reg;

endmodule

// File: doc/dsd_cpu_cpu_debug_ocimem_ctl.md
DSD_CPU_CPU_DEBUG_OCIMEM_CTL -- requirements
Module: dsd_cpu_cpu_debug_ocimem_ctl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the debug RAM.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255, maximum consecutive ram_waitrequest cycles before abort.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port jdo, input, 38, debug-slave data word (sysclk domain).
REQ-006 SHALL have port take_action_ocimem_a, input, 1, load address from jdo[ADDR_W+25:26] and start a read.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1, increment address and start a read.
REQ-008 SHALL have port take_action_ocimem_b, input, 1, write jdo[34:3] at the current address.
REQ-009 SHALL have ports ram_addr (out, ADDR_W), ram_rd (out, 1), ram_wr (out, 1), ram_wdata (out, 32), ram_rdata (in, 32), ram_waitrequest (in, 1): Avalon-style master to the debug RAM, fixed read latency 1.
REQ-010 SHALL have port MonDReg, output, 32, last read data returned to the debug slave.
REQ-011 SHALL have ports monitor_ready (out, 1, operation complete) and monitor_error (out, 1, sticky error).

Function
REQ-012 SHALL implement states IDLE, RD_REQ, RD_DATA, WR_REQ.
REQ-013 In IDLE, a command strobe in cycle T SHALL be accepted, monitor_ready SHALL fall at T+1, and ram_rd or ram_wr SHALL assert from T+1.
REQ-014 Simultaneous strobes SHALL resolve ocimem_b > action_ocimem_a > no_action_ocimem_a; losers are discarded without error.
REQ-015 A strobe arriving outside IDLE SHALL be dropped and SHALL set monitor_error.
REQ-016 RD_REQ SHALL hold ram_rd and ram_addr stable until a cycle with ram_waitrequest low, then go to RD_DATA.
REQ-017 RD_DATA SHALL capture ram_rdata into MonDReg, set monitor_ready, and return to IDLE (read latency from strobe to monitor_ready: 3 cycles with zero wait).
REQ-018 WR_REQ SHALL hold ram_wr, ram_addr, ram_wdata stable until ram_waitrequest low, then increment the address, set monitor_ready, and return to IDLE.
REQ-019 Address increment SHALL be modulo 2^ADDR_W (all-ones wraps to 0).
REQ-020 take_no_action_ocimem_a SHALL increment the address before issuing the read.
REQ-021 take_action_ocimem_a with jdo[25]=1 SHALL clear monitor_error in the accept cycle; monitor_error is otherwise sticky.
REQ-022 ram_rd and ram_wr SHALL never be asserted together and SHALL be low in IDLE and RD_DATA.

Reset
REQ-023 Reset SHALL asynchronously force state IDLE, address 0, MonDReg 0, monitor_ready 0, monitor_error 0, ram_rd 0, ram_wr 0, ram_wdata 0, and clear the timeout counter.
REQ-024 Reset mid-transfer SHALL abandon the transfer; no address increment occurs and no MonDReg update occurs.

Configuration
REQ-025 Macro DSD_CPU_OCIMEM_TIMEOUT_EN SHALL compile in an 8-bit-or-wider wait counter.
REQ-026 With the macro, reaching TIMEOUT_CYC consecutive waitrequest cycles in RD_REQ or WR_REQ SHALL deassert the request, set monitor_error and monitor_ready, load MonDReg with 32'hDEADDEAD on reads, not increment the address, and return to IDLE.
REQ-027 Without the macro, the block SHALL wait indefinitely and monitor_error is set only by REQ-015.

Verification
REQ-028 action_ocimem_a, jdo[33:26]=8'h10, RAM word 0x10=32'h12345678, no wait -> ram_rd one cycle at addr 0x10, MonDReg=32'h12345678, monitor_ready high 3 cycles after strobe.
REQ-029 ocimem_b, jdo[34:3]=32'hCAFEF00D, addr 0xFF, 2 wait cycles -> ram_wr held 3 cycles, address wraps to 0x00, monitor_ready set.
REQ-030 no_action_ocimem_a strobe during RD_REQ -> strobe dropped, monitor_error=1; later action_ocimem_a with jdo[25]=1 -> monitor_error=0.
REQ-031 All three strobes in the same cycle -> only a write issued, address +1, monitor_error stays 0.
REQ-032 With DSD_CPU_OCIMEM_TIMEOUT_EN, ram_waitrequest stuck high on a read -> abort after 255 cycles, MonDReg=32'hDEADDEAD, monitor_error=1; without the macro, ram_rd stays asserted.
REQ-033 reset pulsed during WR_REQ -> all outputs 0 within the reset cycle, address 0, state IDLE.
